vga_timing_gen: RTL and testbench

//  640x480@60Hz VGA raster timing generator; runs on a 25 MHz pixel clock.

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_timing_gen_if.sv | 21 ++
 rtl/vga_axis_counter.sv | 46 ++++
 rtl/vga_timing_gen.sv | 98 +++++++++
 tb/tb_vga_timing_gen.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants for vga_timing_gen.
// Optional frame pulse output is enabled by defining VGA_TIMING_FRAME_PULSE_EN.
package vga_timing_pkg;

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned VCOUNT_W = 9;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam logic HSYNC_POL = 1'b0;
  localparam logic VSYNC_POL = 1'b0;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOTAL      = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL      = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  // Lines at or beyond this index read back as all-ones on the 9-bit VCount.
  localparam int unsigned VCOUNT_SAT   = 1 << VCOUNT_W;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of vga_timing_gen; frame_start exists only with
// VGA_TIMING_FRAME_PULSE_EN defined.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic                hsync;
  logic                vsync;
  logic [CNT_W-1:0]    HCount;
  logic [VCOUNT_W-1:0] VCount;
  logic                active_video;
`ifdef VGA_TIMING_FRAME_PULSE_EN
  logic                frame_start;

  modport master (output hsync, vsync, HCount, VCount, active_video, frame_start);
  modport slave  (input  hsync, vsync, HCount, VCount, active_video, frame_start);
`else
  modport master (output hsync, vsync, HCount, VCount, active_video);
  modport slave  (input  hsync, vsync, HCount, VCount, active_video);
`endif

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus sync-window / active decode
// of the value the counter takes on the next edge.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = H_ACTIVE,
  parameter int unsigned FP     = H_FP,
  parameter int unsigned SYNC   = H_SYNC,
  parameter int unsigned BP     = H_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             sync_nxt,
  output logic             act_nxt
);

  localparam int unsigned      TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);

  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (en) begin
      cnt_nxt = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign sync_nxt = (cnt_nxt >= SYNC_FIRST) && (cnt_nxt <= SYNC_LAST);
  assign act_nxt  = (cnt_nxt < ACT_END);

  // Reset parks on the last position so the first edge lands on zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LAST;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing generator (hsync/vsync, coordinates, active video).
// Define VGA_TIMING_FRAME_PULSE_EN to add the one-cycle frame_start output.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP      = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP      = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE  = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP      = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP      = vga_timing_pkg::V_BP,
  parameter logic        HSYNC_POL = vga_timing_pkg::HSYNC_POL,
  parameter logic        VSYNC_POL = vga_timing_pkg::VSYNC_POL
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vga_timing_gen_if.master       vga
);

  localparam int unsigned W       = vga_timing_pkg::CNT_W;
  localparam int unsigned VW      = vga_timing_pkg::VCOUNT_W;
  localparam int unsigned H_TOTAL = vga_timing_pkg::axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam logic [W-1:0] H_LAST = W'(H_TOTAL - 1);
  localparam logic [W-1:0] V_SAT  = W'(vga_timing_pkg::VCOUNT_SAT);

  logic [W-1:0] h_cnt, v_cnt;
  logic         h_wrap;
  logic         h_sync_nxt, h_act_nxt, v_sync_nxt, v_act_nxt;
  logic         hsync_q, vsync_q, active_q;

  assign h_wrap = (h_cnt == H_LAST);

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (1'b1),
    .cnt      (h_cnt),
    .sync_nxt (h_sync_nxt),
    .act_nxt  (h_act_nxt)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (h_wrap),
    .cnt      (v_cnt),
    .sync_nxt (v_sync_nxt),
    .act_nxt  (v_act_nxt)
  );

  // Qualifiers are registered from the next counter values so they line up
  // with HCount/VCount in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q  <= ~HSYNC_POL;
      vsync_q  <= ~VSYNC_POL;
      active_q <= 1'b0;
    end else begin
      hsync_q  <= h_sync_nxt ? HSYNC_POL : ~HSYNC_POL;
      vsync_q  <= v_sync_nxt ? VSYNC_POL : ~VSYNC_POL;
      active_q <= h_act_nxt && v_act_nxt;
    end
  end

  assign vga.hsync        = hsync_q;
  assign vga.vsync        = vsync_q;
  assign vga.active_video = active_q;
  assign vga.HCount       = h_cnt;
  assign vga.VCount       = (v_cnt < V_SAT) ? v_cnt[VW-1:0] : '1;

`ifdef VGA_TIMING_FRAME_PULSE_EN
  localparam int unsigned V_TOTAL = vga_timing_pkg::axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [W-1:0] V_LAST = W'(V_TOTAL - 1);

  logic frame_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= 1'b0;
    end else begin
      frame_q <= h_wrap && (v_cnt == V_LAST);
    end
  end

  assign vga.frame_start = frame_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full 640x480 instance plus a narrow-line instance
// (16-pixel lines, real vertical timing) so whole frames fit in a short run.
module tb_vga_timing_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  vga_timing_gen_if vga_full ();
  vga_timing_gen_if vga_small ();

  vga_timing_gen u_full (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (vga_full)
  );

  vga_timing_gen #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (3)
  ) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (vga_small)
  );

  logic fs_full, fs_small;
`ifdef VGA_TIMING_FRAME_PULSE_EN
  assign fs_full  = vga_full.frame_start;
  assign fs_small = vga_small.frame_start;
`else
  assign fs_full  = 1'b0;
  assign fs_small = 1'b0;
`endif

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned k        = 0;  // rising edges since reset release

  // Edge tracking for directed window checks.
  logic        prev_hs_f = 1'b1, prev_av_f = 1'b0, prev_vs_s = 1'b1, prev_fs_s = 1'b0;
  bit          have_vfall = 1'b0, have_fs = 1'b0;
  int unsigned last_vfall = 0, last_fs = 0;
  int unsigned n_vintervals = 0, n_fsintervals = 0;

  // Outputs as a function of linear frame position: edge k shows pixel k-1,
  // reset shows the last pixel of the frame.
  function automatic logic [22:0] model(input int unsigned kk, input int unsigned ha,
                                        input int unsigned hf, input int unsigned hsw,
                                        input int unsigned hb);
    int unsigned ht, vt, p, h, v;
    logic hs, vs, av, fs;
    logic [9:0] hc;
    logic [8:0] vc;
    ht = ha + hf + hsw + hb;
    vt = 525;
    p  = (kk + ht * vt - 1) % (ht * vt);
    h  = p % ht;
    v  = p / ht;
    hs = !((h >= ha + hf) && (h < ha + hf + hsw));
    vs = !((v >= 490) && (v < 492));
    av = (h < ha) && (v < 480);
    hc = 10'(h);
    vc = (v < 512) ? 9'(v) : 9'h1FF;
    fs = 1'b0;
`ifdef VGA_TIMING_FRAME_PULSE_EN
    fs = (h == 0) && (v == 0);
`endif
    return {hs, vs, hc, vc, av, fs};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag);
    logic [22:0] obs_f, obs_s;
    obs_f = {vga_full.hsync, vga_full.vsync, vga_full.HCount, vga_full.VCount,
             vga_full.active_video, fs_full};
    obs_s = {vga_small.hsync, vga_small.vsync, vga_small.HCount, vga_small.VCount,
             vga_small.active_video, fs_small};
    check({tag, "_full"},  64'(obs_f), 64'(model(k, 640, 16, 96, 48)));
    check({tag, "_small"}, 64'(obs_s), 64'(model(k, 8, 2, 3, 3)));
  endtask

  task automatic run(input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      check_both(tag);
      if (prev_hs_f && !vga_full.hsync)      check("hsync_fall_col", 64'(vga_full.HCount), 64'd656);
      if (!prev_hs_f && vga_full.hsync)      check("hsync_rise_col", 64'(vga_full.HCount), 64'd752);
      if (prev_av_f && !vga_full.active_video) check("active_end_col", 64'(vga_full.HCount), 64'd640);
      if (prev_vs_s && !vga_small.vsync) begin
        if (have_vfall) begin
          check("vsync_period", 64'(k - last_vfall), 64'd8400);
          n_vintervals++;
        end
        have_vfall = 1'b1;
        last_vfall = k;
      end
      if (!prev_fs_s && fs_small) begin
        if (have_fs) begin
          check("frame_start_period", 64'(k - last_fs), 64'd8400);
          n_fsintervals++;
        end
        have_fs = 1'b1;
        last_fs = k;
      end
      prev_hs_f = vga_full.hsync;
      prev_av_f = vga_full.active_video;
      prev_vs_s = vga_small.vsync;
      prev_fs_s = fs_small;
    end
  endtask

  initial begin
    int unsigned n_a;

    // Held in reset across several edges.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_both("reset_hold");

    rst_n = 1'b1;
    n_a   = $urandom_range(2999, 1000);
    run(n_a, "phase_a");

    // Asynchronous reset mid-line: outputs must change before any clock edge.
    #5 rst_n = 1'b0;
    #1 k = 0;
    check_both("async_reset");
    prev_hs_f  = 1'b1;
    prev_av_f  = 1'b0;
    prev_vs_s  = 1'b1;
    prev_fs_s  = 1'b0;
    have_vfall = 1'b0;
    have_fs    = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check_both("reset_hold2");
    end

    rst_n = 1'b1;
    run(17000, "phase_b");

    check("vsync_interval_count", 64'(n_vintervals), 64'd1);
`ifdef VGA_TIMING_FRAME_PULSE_EN
    check("frame_start_interval_count", 64'(n_fsintervals), 64'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
